td4_clk_ctrl: RTL
=================

Name: td4_clk_ctrl

Overview:
- Sits directly downstream of the PLL wrapper.
- Consumes the PLL's divided 10 MHz clock output and its lock indication.
- Produces a synchronised CPU reset and a single-cycle CPU clock-enable for the TD4 core.
- The enable rate is selectable: manual step from a debounced push-button, 1 Hz, 10 Hz, or full rate.

Parameters:
- CLK_HZ, 10000000: frequency of clk in Hz; sets prescaler terminal counts.
- DEB_CYC, 100000: cycles btn_step must be stable before a level change is accepted (10 ms at 10 MHz).
- LOCK_CYC, 16: consecutive cycles of synchronised lock required before cpu_rst releases.

Ports:
- clk  in  1  divided PLL output clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- lock  in  1  PLL lock, asynchronous to clk.
- btn_step  in  1  raw step push-button, active high, bouncy, asynchronous.
- spd_sel  in  2  rate select: 00 manual, 01 1 Hz, 10 10 Hz, 11 full rate; quasi-static.
- cpu_rst  out  1  active-high reset to the CPU.
- cpu_ce  out  1  CPU clock-enable, one-cycle pulses except in full-rate mode.
- ce_led  out  1  toggles on every cpu_ce cycle; drives a status LED.

Behaviour:
- Reset values (rst high, asynchronous): cpu_rst=1, cpu_ce=0, ce_led=0, all counters 0, debounced button state 0, FSM=HOLD.
- Synchronisers:
  - lock and btn_step each pass through a 2-FF synchroniser reset to 0.
  - Call the outputs lock_s and btn_s.
- Reset FSM:
  - HOLD: cpu_rst=1. lock_cnt increments while lock_s=1 and clears to 0 when lock_s=0. When lock_cnt reaches LOCK_CYC-1 with lock_s=1, go to RUN; cpu_rst drops on the next edge (registered).
  - RUN: cpu_rst=0. If lock_s=0 in any cycle, go to HOLD; cpu_rst=1 from the next edge; lock_cnt=0.
  - Lock loss mid-pulse: cpu_ce is forced 0 in the same cycle cpu_rst rises.
- Debouncer:
  - deb_cnt clears whenever btn_s equals the debounced state.
  - Otherwise deb_cnt increments; when it reaches DEB_CYC-1, the debounced state takes btn_s and deb_cnt clears.
  - A 0->1 transition of the debounced state produces a one-cycle step_p.
  - The debouncer runs in both HOLD and RUN.
- Prescaler:
  - Terminal count is CLK_HZ-1 (1 Hz) or CLK_HZ/10-1 (10 Hz). Width is clog2(CLK_HZ).
  - Counts 0..TC and wraps to 0. tick=1 in the cycle the counter equals TC.
  - Counter is held at 0 while cpu_rst=1 or spd_sel is 00/11.
  - Any change of spd_sel, detected by comparison with a registered copy, clears the counter the following cycle.
  - Result: the first 1 Hz tick after release occurs exactly CLK_HZ cycles after cpu_rst falls.
- cpu_ce (registered) is 0 whenever the FSM is HOLD. In RUN:
  - 00: cpu_ce = step_p delayed one cycle.
  - 01/10: cpu_ce = tick delayed one cycle.
  - 11: cpu_ce=1 continuously.
- ce_led inverts on every clock edge where cpu_ce=1.
- Simultaneous events:
  - A step press while in HOLD is discarded, not queued.
  - step_p in a timed mode is ignored, unless TD4_STEP_OVERRIDE_EN is defined.

Optional Feature:
- Macro: TD4_STEP_OVERRIDE_EN.
- Defined:
  - In modes 01/10, step_p also produces a cpu_ce pulse and clears the prescaler, so the next tick occurs TC+1 cycles later.
  - If step_p and tick coincide, exactly one pulse is emitted.
  - Mode 11 is unaffected.
- Not defined: step_p affects cpu_ce only in mode 00.

Test Plan (CLK_HZ=100, DEB_CYC=4, LOCK_CYC=16):
1. Lock bring-up: rst pulse, then lock=1 at cycle 5 -> cpu_rst stays 1 until lock_s has been high 16 cycles, falls on the following edge; cpu_ce=0 throughout.
2. Lock glitch: drop lock for 1 cycle after cpu_rst falls -> cpu_rst=1 within 3 cycles, cpu_ce=0; re-release needs 16 fresh lock cycles.
3. Bounce: in mode 00, toggle btn_step 1,0,1,0 every 2 cycles, then hold 1 for 10 cycles -> exactly one cpu_ce pulse, ce_led toggles once.
4. Rates: mode 01 -> cpu_ce pulses every 100 cycles, first 100 cycles after release. Mode 10 -> period 10. Switch 10->01 mid-count -> next pulse 100 cycles after the switch.
5. Full rate: mode 11 -> cpu_ce constant 1 in RUN, ce_led toggles every cycle; assert rst mid-run -> cpu_ce=0, cpu_rst=1 immediately.
6. Override (macro on): in mode 01, press at cycle 40 of the period -> cpu_ce pulse after debounce, next tick 100 cycles later. Macro off -> no pulse, period unchanged.

Source files
------------

// File: rtl/td4_clk_ctrl.sv
// td4_clk_ctrl: CPU reset and clock-enable generator for the TD4 core.
// Holds the CPU in reset until the PLL lock has been stable, debounces the
// step button and emits cpu_ce at manual, 1 Hz, 10 Hz or full rate.
// Optional build macro TD4_STEP_OVERRIDE_EN: in the timed modes a step press
// also fires cpu_ce and restarts the prescaler period.
module td4_clk_ctrl #(
  parameter int unsigned CLK_HZ   = 10000000,
  parameter int unsigned DEB_CYC  = 100000,
  parameter int unsigned LOCK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lock,
  input  logic       btn_step,
  input  logic [1:0] spd_sel,
  output logic       cpu_rst,
  output logic       cpu_ce,
  output logic       ce_led
);

  localparam int unsigned PreW  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DebW  = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int unsigned LockW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

  localparam logic [PreW-1:0]  Tc1Hz  = PreW'(CLK_HZ - 1);
  localparam logic [PreW-1:0]  Tc10Hz = PreW'(CLK_HZ / 10 - 1);
  localparam logic [DebW-1:0]  DebTc  = DebW'(DEB_CYC - 1);
  localparam logic [LockW-1:0] LockTc = LockW'(LOCK_CYC - 1);

  localparam logic [1:0] SpdManual = 2'b00;
  localparam logic [1:0] Spd1Hz    = 2'b01;
  localparam logic [1:0] Spd10Hz   = 2'b10;
  localparam logic [1:0] SpdFull   = 2'b11;

  typedef enum logic [0:0] {
    StHold,
    StRun
  } state_e;

  logic             lock_m, lock_s;
  logic             btn_m, btn_s;
  state_e           state_q;
  logic [LockW-1:0] lock_cnt_q;
  logic             cpu_rst_q, cpu_ce_q, ce_led_q;
  logic [DebW-1:0]  deb_cnt_q;
  logic             deb_q, deb_prev_q;
  logic [PreW-1:0]  pre_cnt_q;
  logic [1:0]       spd_q;

  logic            timed, sel_chg, step_p, tick, step_clr, ce_next;
  logic [PreW-1:0] pre_tc;

  assign cpu_rst = cpu_rst_q;
  assign cpu_ce  = cpu_ce_q;
  assign ce_led  = ce_led_q;

  // Two-flop synchronisers for the asynchronous lock and button inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      btn_m  <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      lock_m <= lock;
      lock_s <= lock_m;
      btn_m  <= btn_step;
      btn_s  <= btn_m;
    end
  end

  // Decode rate, prescaler tick and the cpu_ce request for the next cycle.
  always_comb begin
    timed    = (spd_sel == Spd1Hz) || (spd_sel == Spd10Hz);
    pre_tc   = (spd_sel == Spd1Hz) ? Tc1Hz : Tc10Hz;
    sel_chg  = (spd_sel != spd_q);
    step_p   = deb_q & ~deb_prev_q;
    // Masked on a rate change so a stale count cannot fire against the new TC.
    tick     = timed & ~sel_chg & ~cpu_rst_q & (pre_cnt_q == pre_tc);
    step_clr = 1'b0;
    ce_next  = 1'b0;
    case (spd_sel)
      SpdManual: ce_next = step_p;
      Spd1Hz, Spd10Hz: begin
`ifdef TD4_STEP_OVERRIDE_EN
        // A coinciding step and tick still yield a single pulse.
        ce_next  = tick | step_p;
        step_clr = step_p;
`else
        ce_next  = tick;
`endif
      end
      SpdFull:   ce_next = 1'b1;
      default:   ce_next = 1'b0;
    endcase
  end

  // Reset FSM: wait for LOCK_CYC cycles of stable lock, drop back on any loss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StHold;
      lock_cnt_q <= '0;
      cpu_rst_q  <= 1'b1;
      cpu_ce_q   <= 1'b0;
    end else begin
      case (state_q)
        StHold: begin
          cpu_ce_q <= 1'b0;
          if (!lock_s) begin
            lock_cnt_q <= '0;
          end else if (lock_cnt_q == LockTc) begin
            state_q    <= StRun;
            cpu_rst_q  <= 1'b0;
            lock_cnt_q <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_q + LockW'(1);
          end
        end
        StRun: begin
          if (!lock_s) begin
            // cpu_ce must be low in the same cycle cpu_rst reasserts.
            state_q    <= StHold;
            cpu_rst_q  <= 1'b1;
            cpu_ce_q   <= 1'b0;
            lock_cnt_q <= '0;
          end else begin
            cpu_ce_q <= ce_next;
          end
        end
        default: begin
          state_q   <= StHold;
          cpu_rst_q <= 1'b1;
          cpu_ce_q  <= 1'b0;
        end
      endcase
    end
  end

  // Status LED flips once per enabled CPU cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_led_q <= 1'b0;
    end else if (cpu_ce_q) begin
      ce_led_q <= ~ce_led_q;
    end
  end

  // Debouncer: accept a new button level after DEB_CYC stable cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_q  <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
    end else begin
      deb_prev_q <= deb_q;
      if (btn_s == deb_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DebTc) begin
        deb_q     <= btn_s;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + DebW'(1);
      end
    end
  end

  // Prescaler: held in reset and untimed modes, restarted on a rate change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
      spd_q     <= SpdManual;
    end else begin
      spd_q <= spd_sel;
      if (cpu_rst_q || !timed || sel_chg || step_clr || (pre_cnt_q >= pre_tc)) begin
        pre_cnt_q <= '0;
      end else begin
        pre_cnt_q <= pre_cnt_q + PreW'(1);
      end
    end
  end

endmodule
